// File: rtl/cora_nn_pkg.sv
// Shared definitions for the neuron layer: FSM encoding and default datapath constants.
// Membrane values are 16-bit signed Q15.0 integers; MAC results are rescaled into that range.
package cora_nn_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_CALC  = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_LOAD  = ST_LOAD,
        S_CALC  = ST_CALC,
        S_WRITE = ST_WRITE
    } lif_state_t;

    localparam int                 DEF_IN_SHIFT   = 8;
    localparam int                 DEF_LEAK_SHIFT = 4;
    localparam logic signed [15:0] DEF_THRESH     = 16'sd4096;
    localparam logic signed [15:0] DEF_V_RESET    = 16'sd0;

endpackage

// File: rtl/sat16_shift.sv
// Arithmetic right shift of an IN_W-bit signed value followed by clamping to 16-bit signed.
module sat16_shift #(
    parameter int IN_W  = 32,
    parameter int SHIFT = 0
) (
    input  logic signed [IN_W-1:0] i_din,
    output logic signed [15:0]     o_dout
);

    localparam logic signed [IN_W-1:0] C_MAX = IN_W'(32767);
    localparam logic signed [IN_W-1:0] C_MIN = IN_W'(-32768);

    logic signed [IN_W-1:0] w_shifted;

    assign w_shifted = i_din >>> SHIFT;

    always_comb begin
        o_dout = w_shifted[15:0];
        if (w_shifted > C_MAX) begin
            o_dout = 16'sh7FFF;
        end else if (w_shifted < C_MIN) begin
            o_dout = 16'sh8000;
        end
    end

endmodule

// File: rtl/lif_neuron_update.sv
// Leaky integrate-and-fire update for one neuron per MAC result; membranes held in flops.
// state | meaning
// IDLE  | ready for a MAC result
// LOAD  | rescale input, fetch membrane
// CALC  | leak, integrate, threshold compare; present outputs
// WRITE | write back membrane and spike flag, out_valid high
module lif_neuron_update
    import cora_nn_pkg::*;
#(
    parameter int                 NUM_NEURONS = 16,
    parameter int                 IDX_W       = 4,
    parameter int                 IN_SHIFT    = DEF_IN_SHIFT,
    parameter int                 LEAK_SHIFT  = DEF_LEAK_SHIFT,
    parameter logic signed [15:0] THRESH      = DEF_THRESH,
    parameter logic signed [15:0] V_RESET     = DEF_V_RESET
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_state,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [31:0]     in_mac,
    input  logic [IDX_W-1:0]       in_idx,
    output logic                   out_valid,
    output logic                   out_spike,
    output logic [IDX_W-1:0]       out_idx,
    output logic signed [15:0]     out_v,
    output logic [NUM_NEURONS-1:0] spike_vec
);

    lif_state_t r_state;
    lif_state_t w_state_nxt;

    logic signed [31:0]     r_mac;
    logic [IDX_W-1:0]       r_idx;
    logic signed [15:0]     r_scaled;
    logic signed [15:0]     r_v;
    logic signed [15:0]     r_vnew;
    logic                   r_spike;
    logic signed [15:0]     r_mem [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] r_spike_vec;
    logic                   r_out_valid;
    logic                   r_out_spike;
    logic [IDX_W-1:0]       r_out_idx;
    logic signed [15:0]     r_out_v;

    logic                   w_accept;
    logic signed [15:0]     w_scaled;
    logic signed [15:0]     w_leak;
    logic signed [16:0]     w_sum;
    logic signed [15:0]     w_vnew;
    logic                   w_spike;

    assign in_ready = (r_state == S_IDLE) & ~clear_state;
    assign w_accept = in_valid & in_ready;

    sat16_shift #(.IN_W(32), .SHIFT(IN_SHIFT)) u_in_scale (
        .i_din  (r_mac),
        .o_dout (w_scaled)
    );

    // The leak never overflows 16 bits; only the integrate sum needs the 17th bit.
    assign w_leak = r_v - (r_v >>> LEAK_SHIFT);
    assign w_sum  = {w_leak[15], w_leak} + {r_scaled[15], r_scaled};

    sat16_shift #(.IN_W(17), .SHIFT(0)) u_sum_sat (
        .i_din  (w_sum),
        .o_dout (w_vnew)
    );

    assign w_spike = (w_vnew >= THRESH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (clear_state) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_CALC;
            S_CALC:  w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mac       <= '0;
            r_idx       <= '0;
            r_scaled    <= '0;
            r_v         <= '0;
            r_vnew      <= '0;
            r_spike     <= 1'b0;
            r_spike_vec <= '0;
            r_out_valid <= 1'b0;
            r_out_spike <= 1'b0;
            r_out_idx   <= '0;
            r_out_v     <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) r_mem[i] <= '0;
        end else if (clear_state) begin
            r_spike_vec <= '0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) r_mem[i] <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mac <= in_mac;
                        r_idx <= in_idx;
                    end
                end
                S_LOAD: begin
                    r_scaled <= w_scaled;
                    r_v      <= r_mem[r_idx];
                end
                S_CALC: begin
                    r_vnew      <= w_vnew;
                    r_spike     <= w_spike;
                    r_out_valid <= 1'b1;
                    r_out_spike <= w_spike;
                    r_out_idx   <= r_idx;
                    r_out_v     <= w_spike ? V_RESET : w_vnew;
                end
                S_WRITE: begin
                    r_mem[r_idx] <= r_spike ? V_RESET : r_vnew;
                    if (r_spike) r_spike_vec[r_idx] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A clear or reset landing in WRITE aborts the update, so the pulse is suppressed too.
    assign out_valid = r_out_valid & ~clear_state & ~rst;
    assign out_spike = r_out_spike;
    assign out_idx   = r_out_idx;
    assign out_v     = r_out_v;
    assign spike_vec = r_spike_vec;

endmodule

// File: tb/tb_lif_neuron_update.sv
// Self-checking bench for lif_neuron_update: expected updates queued at drive time, popped on out_valid.
module tb_lif_neuron_update;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clear_state = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [31:0] in_mac = '0;
    logic [3:0]         in_idx = '0;
    logic               out_valid;
    logic               out_spike;
    logic [3:0]         out_idx;
    logic signed [15:0] out_v;
    logic [15:0]        spike_vec;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]         idx;
        logic signed [15:0] v;
        logic               spike;
    } exp_t;

    exp_t sb_q[$];

    lif_neuron_update dut (
        .clk         (clk),
        .rst         (rst),
        .clear_state (clear_state),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mac      (in_mac),
        .in_idx      (in_idx),
        .out_valid   (out_valid),
        .out_spike   (out_spike),
        .out_idx     (out_idx),
        .out_v       (out_v),
        .spike_vec   (spike_vec)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Waits (bounded) for in_ready, then presents one in_valid pulse; returns just after the accepting edge.
    task automatic send(input logic signed [31:0] mac, input logic [3:0] idx, output bit ok);
        int waited;
        waited = 0;
        ok = 1'b0;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: in_ready=%0b required 1", in_ready);
        end else begin
            in_mac   = mac;
            in_idx   = idx;
            in_valid = 1'b1;
            ok       = 1'b1;
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic update(input string name, input logic signed [31:0] mac, input logic [3:0] idx,
                          input logic signed [15:0] exp_v, input logic exp_spike);
        exp_t e;
        bit   ok;
        int   lat;
        e.idx = idx; e.v = exp_v; e.spike = exp_spike;
        sb_q.push_back(e);
        send(mac, idx, ok);
        if (!ok) begin
            sb_q.delete();
            return;
        end
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (out_valid !== 1'b1 && lat < 10);
        n_checks++;
        if (out_valid !== 1'b1 || lat != 2) begin
            n_fail++;
            $display("FAIL %s latency: out_valid=%0b after %0d edges, required 1 after 2 (cycle 3)", name, out_valid, lat);
        end
        if (out_valid === 1'b1 && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks++;
            if (out_idx !== e.idx) begin
                n_fail++;
                $display("FAIL %s out_idx: got %0d required %0d", name, out_idx, e.idx);
            end
            n_checks++;
            if (out_v !== e.v) begin
                n_fail++;
                $display("FAIL %s out_v: got %0d required %0d", name, out_v, e.v);
            end
            n_checks++;
            if (out_spike !== e.spike) begin
                n_fail++;
                $display("FAIL %s out_spike: got %0b required %0b", name, out_spike, e.spike);
            end
        end else begin
            sb_q.delete();
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s cycle4: out_valid=%0b in_ready=%0b required 0 and 1", name, out_valid, in_ready);
        end
    endtask

    task automatic count_valid(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_spike !== 1'b0 || out_idx !== 4'd0 ||
            out_v !== 16'sd0 || spike_vec !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_values: ready=%0b valid=%0b spike=%0b idx=%0d v=%0d vec=%h required 1 0 0 0 0 0000",
                     in_ready, out_valid, out_spike, out_idx, out_v, spike_vec);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_integrate();
        update("integ1", 32'sd262144, 4'd3, 16'sd1024, 1'b0);
        update("integ2", 32'sd262144, 4'd3, 16'sd1984, 1'b0);
        update("integ3", 32'sd262144, 4'd3, 16'sd2884, 1'b0);
        update("integ4", 32'sd262144, 4'd3, 16'sd3728, 1'b0);
        update("integ5", 32'sd262144, 4'd3, 16'sd0,    1'b1);
        n_checks++;
        if (spike_vec !== 16'h0008) begin
            n_fail++;
            $display("FAIL integ_spike_vec: got %h required 0008", spike_vec);
        end
    endtask

    task automatic test_pos_sat();
        update("pos_sat", 32'sh7FFF_FFFF, 4'd0, 16'sd0, 1'b1);
        n_checks++;
        if (spike_vec !== 16'h0009) begin
            n_fail++;
            $display("FAIL pos_sat_spike_vec: got %h required 0009", spike_vec);
        end
    endtask

    task automatic test_neg_sat();
        update("neg_sat",  -32'sd16777216, 4'd5, -16'sd32768, 1'b0);
        update("neg_leak", 32'sd0,         4'd5, -16'sd30720, 1'b0);
    endtask

    task automatic test_handshake();
        exp_t e;
        bit   ok;
        int   cnt;
        e.idx = 4'd7; e.v = 16'sd1; e.spike = 1'b0;
        sb_q.push_back(e);
        send(32'sd256, 4'd7, ok);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_busy_ready: in_ready=%0b required 0", in_ready);
        end
        in_mac   = 32'sh0010_0000;
        in_idx   = 4'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid === 1'b1) begin
                cnt++;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    n_checks++;
                    if (out_v !== e.v || out_idx !== e.idx || out_spike !== e.spike) begin
                        n_fail++;
                        $display("FAIL hs_result: v=%0d idx=%0d spike=%0b required %0d %0d %0b",
                                 out_v, out_idx, out_spike, e.v, e.idx, e.spike);
                    end
                end
            end
            @(posedge clk); #1;
        end
        sb_q.delete();
        n_checks++;
        if (cnt != 1) begin
            n_fail++;
            $display("FAIL hs_valid_count: got %0d pulses required 1", cnt);
        end
        update("hs_unchanged", 32'sd0, 4'd7, 16'sd1, 1'b0);
    endtask

    task automatic test_clear();
        bit ok;
        int cnt;
        send(32'sd262144, 4'd2, ok);
        @(posedge clk); #1;
        clear_state = 1'b1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_ready: in_ready=%0b required 0", in_ready);
        end
        @(posedge clk); #1;
        clear_state = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || spike_vec !== 16'h0000) begin
            n_fail++;
            $display("FAIL clear_immediate: out_valid=%0b spike_vec=%h required 0 and 0000", out_valid, spike_vec);
        end
        count_valid(6, cnt);
        n_checks++;
        if (cnt != 0) begin
            n_fail++;
            $display("FAIL clear_no_valid: got %0d pulses required 0", cnt);
        end
        update("clear_follow", 32'sd512, 4'd2, 16'sd2, 1'b0);
        update("clear_idx3",   32'sd0,   4'd3, 16'sd0, 1'b0);
    endtask

    task automatic test_rst_mid();
        bit ok;
        int cnt;
        update("rst_pre", 32'sd262144, 4'd1, 16'sd1024, 1'b0);
        send(32'sd262144, 4'd1, ok);
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_spike !== 1'b0 || out_idx !== 4'd0 ||
            out_v !== 16'sd0 || spike_vec !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_mid_values: ready=%0b valid=%0b spike=%0b idx=%0d v=%0d vec=%h required 1 0 0 0 0 0000",
                     in_ready, out_valid, out_spike, out_idx, out_v, spike_vec);
        end
        @(negedge clk);
        rst = 1'b0;
        count_valid(6, cnt);
        n_checks++;
        if (cnt != 0) begin
            n_fail++;
            $display("FAIL rst_mid_no_valid: got %0d pulses required 0", cnt);
        end
        update("rst_post", 32'sd0, 4'd1, 16'sd0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_integrate();
        test_pos_sat();
        test_neg_sat();
        test_handshake();
        test_clear();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
